// File: rtl/systolic_mm_engine_if.sv
// rtl/systolic_mm_engine_if.sv - control, operand stream and result drain bundle of the systolic engine
interface systolic_mm_engine_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 32,
  parameter int K_MAX      = 64
) ();
  localparam int KW = $clog2(K_MAX + 1);
  localparam int RW = $clog2(N);

  logic                    start;
  logic                    acc_clear;
  logic [KW-1:0]           k_len;
  logic                    in_valid;
  logic                    in_ready;
  logic [N*DATA_WIDTH-1:0] a_col;
  logic [N*DATA_WIDTH-1:0] b_row;
  logic                    out_valid;
  logic                    out_ready;
  logic [RW-1:0]           out_row;
  logic [N*ACC_WIDTH-1:0]  out_data;
  logic                    busy;
  logic                    done;

  modport master (
    output start, acc_clear, k_len, in_valid, a_col, b_row, out_ready,
    input  in_ready, out_valid, out_row, out_data, busy, done
  );

  modport slave (
    input  start, acc_clear, k_len, in_valid, a_col, b_row, out_ready,
    output in_ready, out_valid, out_row, out_data, busy, done
  );
endinterface

// File: rtl/systolic_mm_engine.sv
// rtl/systolic_mm_engine.sv - NxN output-stationary systolic matrix-multiply engine with skewed streaming input
module systolic_mm_engine #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 32,
  parameter int K_MAX      = 64
) (
  input logic                  clock,
  input logic                  reset_n,
  systolic_mm_engine_if.slave  bus
);
  localparam int KW = $clog2(K_MAX + 1);
  localparam int RW = $clog2(N);
  localparam int FW = $clog2(2 * N);
  localparam int PW = (2 * DATA_WIDTH > ACC_WIDTH) ? 2 * DATA_WIDTH : ACC_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_t;

  state_t                 state;
  logic [KW-1:0]          k_lat;
  logic [KW-1:0]          beat_cnt;
  logic [FW-1:0]          flush_cnt;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic [RW-1:0]          out_row_q;
  logic [N*ACC_WIDTH-1:0] out_data_q;
  logic                   busy_q;
  logic                   done_q;

  logic signed [DATA_WIDTH-1:0] a_pipe [N][N];
  logic signed [DATA_WIDTH-1:0] b_pipe [N][N];
  logic signed [DATA_WIDTH-1:0] a_reg  [N][N];
  logic signed [DATA_WIDTH-1:0] b_reg  [N][N];
  logic        [ACC_WIDTH-1:0]  acc    [N][N];

  logic signed [DATA_WIDTH-1:0] a_feed  [N];
  logic signed [DATA_WIDTH-1:0] b_feed  [N];
  logic signed [DATA_WIDTH-1:0] a_west  [N];
  logic signed [DATA_WIDTH-1:0] b_north [N];
  logic signed [PW-1:0]         prod     [N][N];
  logic        [ACC_WIDTH-1:0]  acc_next [N][N];

  logic                   accept;
  logic                   adv;
  logic                   ops_clear;
  logic                   acc_zero;
  logic [RW-1:0]          nxt_row;
  logic [N*ACC_WIDTH-1:0] row0_now;
  logic [N*ACC_WIDTH-1:0] row0_flush;
  logic [N*ACC_WIDTH-1:0] row_next;

  assign accept    = (state == S_LOAD) && bus.in_valid && in_ready_q;
  assign adv       = accept || (state == S_FLUSH);
  assign ops_clear = (state == S_IDLE) && bus.start;
  assign acc_zero  = ops_clear && bus.acc_clear;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_row   = out_row_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  // Zeros are injected during FLUSH; row r / column c reach the array r / c advances late.
  always_comb begin
    for (int r = 0; r < N; r++) begin
      a_feed[r] = (state == S_LOAD) ? bus.a_col[r*DATA_WIDTH +: DATA_WIDTH] : '0;
      b_feed[r] = (state == S_LOAD) ? bus.b_row[r*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
    a_west[0]  = a_feed[0];
    b_north[0] = b_feed[0];
    for (int r = 1; r < N; r++) begin
      a_west[r]  = a_pipe[r][r-1];
      b_north[r] = b_pipe[r][r-1];
    end
  end

  always_comb begin
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        prod[r][c]     = PW'(a_reg[r][c]) * PW'(b_reg[r][c]);
        acc_next[r][c] = acc[r][c] + prod[r][c][ACC_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    row0_now   = '0;
    row0_flush = '0;
    row_next   = '0;
    nxt_row    = (out_row_q == RW'(N - 1)) ? '0 : out_row_q + RW'(1);
    for (int c = 0; c < N; c++) begin
      row0_now[c*ACC_WIDTH +: ACC_WIDTH]   = acc[0][c];
      row0_flush[c*ACC_WIDTH +: ACC_WIDTH] = acc_next[0][c];
      row_next[c*ACC_WIDTH +: ACC_WIDTH]   = acc[nxt_row][c];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_pipe[r][c] <= '0;
          b_pipe[r][c] <= '0;
          a_reg[r][c]  <= '0;
          b_reg[r][c]  <= '0;
          acc[r][c]    <= '0;
        end
      end
    end else begin
      if (ops_clear) begin
        for (int r = 0; r < N; r++) begin
          for (int c = 0; c < N; c++) begin
            a_pipe[r][c] <= '0;
            b_pipe[r][c] <= '0;
            a_reg[r][c]  <= '0;
            b_reg[r][c]  <= '0;
          end
        end
      end else if (adv) begin
        for (int r = 0; r < N; r++) begin
          a_pipe[r][0] <= a_feed[r];
          b_pipe[r][0] <= b_feed[r];
          for (int j = 1; j < N; j++) begin
            a_pipe[r][j] <= a_pipe[r][j-1];
            b_pipe[r][j] <= b_pipe[r][j-1];
          end
          a_reg[r][0] <= a_west[r];
          b_reg[0][r] <= b_north[r];
          for (int j = 1; j < N; j++) begin
            a_reg[r][j] <= a_reg[r][j-1];
            b_reg[j][r] <= b_reg[j-1][r];
          end
        end
      end
      // MAC uses the operand regs as they stood before this advance.
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          if (acc_zero)
            acc[r][c] <= '0;
          else if (adv)
            acc[r][c] <= acc_next[r][c];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      k_lat       <= '0;
      beat_cnt    <= '0;
      flush_cnt   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            k_lat     <= bus.k_len;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            busy_q    <= 1'b1;
            if (bus.k_len != '0) begin
              state      <= S_LOAD;
              in_ready_q <= 1'b1;
            end else begin
              state       <= S_DRAIN;
              out_valid_q <= 1'b1;
              out_row_q   <= '0;
              out_data_q  <= bus.acc_clear ? '0 : row0_now;
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            beat_cnt <= beat_cnt + KW'(1);
            if (beat_cnt + KW'(1) == k_lat) begin
              state      <= S_FLUSH;
              in_ready_q <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          // The final flush advance lands its MAC on this edge, so row 0 comes from acc_next.
          if (flush_cnt == FW'(2 * N - 2)) begin
            state       <= S_DRAIN;
            out_valid_q <= 1'b1;
            out_row_q   <= '0;
            out_data_q  <= row0_flush;
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end
        S_DRAIN: begin
          if (bus.out_ready) begin
            if (out_row_q == RW'(N - 1)) begin
              state       <= S_IDLE;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              out_row_q  <= nxt_row;
              out_data_q <= row_next;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_mm_engine.sv
// tb/tb_systolic_mm_engine.sv - table-driven and randomized bench for systolic_mm_engine against a matrix model
module tb_systolic_mm_engine;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int KM = 64;
  localparam int KW = $clog2(KM + 1);
  localparam int GEN_KEEP = 0, GEN_IDENT = 1, GEN_RAND = 2;

  typedef struct {
    bit clr;
    int k;
    int off;
    int gen;
    int stall;
    int hold;
    bit noise;
    int lat;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  systolic_mm_engine_if #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_MAX(KM)) bus ();
  systolic_mm_engine #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_MAX(KM)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int ga [N][KM];
  int gb [KM][N];
  int cm [N][N];
  vec_t tbl [10];

  task automatic check(input string nm, input logic [N*AW-1:0] act, input logic [N*AW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic gen_mats(input int g);
    for (int r = 0; r < N; r++) begin
      for (int k = 0; k < KM; k++) begin
        if (g == GEN_IDENT) begin
          ga[r][k] = (r == k) ? 1 : 0;
          gb[k][r] = k * N + r;
        end else if (g == GEN_RAND) begin
          ga[r][k] = $urandom;
          gb[k][r] = $urandom;
        end
      end
    end
  endtask

  task automatic apply_model(input bit clr, input int k, input int off);
    if (clr)
      for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) cm[r][c] = 0;
    for (int b = 0; b < k; b++)
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          cm[r][c] += int'(longint'(ga[r][off+b]) * longint'(gb[off+b][c]));
  endtask

  function automatic logic [N*AW-1:0] exp_row(input int row);
    logic [N*AW-1:0] v;
    v = '0;
    for (int c = 0; c < N; c++) v[c*AW +: AW] = cm[row][c];
    return v;
  endfunction

  task automatic idle_inputs();
    bus.start = 1'b0; bus.acc_clear = 1'b0; bus.k_len = '0; bus.in_valid = 1'b0;
    bus.a_col = '0; bus.b_row = '0; bus.out_ready = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_row"}, bus.out_row, 0);
    check({tag, "_out_data"}, bus.out_data, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
  endtask

  task automatic run_op(input vec_t v);
    int beat, nr, extra, first_ov, last_hs, held;
    bit pend, fin, ordy, vld;
    logic [N*AW-1:0] prow, pdata;
    if (v.gen != GEN_KEEP) gen_mats(v.gen);
    apply_model(v.clr, v.k, v.off);
    bus.start = 1'b1; bus.acc_clear = v.clr; bus.k_len = KW'(v.k);
    @(posedge clock); #1;
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    beat = 0; nr = 0; extra = 0; first_ov = -1; last_hs = -100; held = 0;
    pend = 0; fin = 0; prow = '0; pdata = '0;
    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      if (pend) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_row", bus.out_row, prow);
        check("hold_data", bus.out_data, pdata);
      end
      if (bus.done) begin
        check("done_rows", nr, N);
        check("done_delay", cyc - last_hs, 1);
        check("done_valid_low", bus.out_valid, 0);
        check("done_not_busy", bus.busy, 0);
        fin = 1;
      end else begin
        if (bus.in_ready && beat >= v.k) extra++;
        if (bus.out_valid && first_ov < 0) first_ov = cyc;
        case (v.hold)
          0: ordy = 1'b1;
          1: begin
            ordy = !(bus.out_valid && bus.out_row == 1 && held < 5);
            if (!ordy) held++;
          end
          default: ordy = 1'($urandom_range(0, 1));
        endcase
        bus.out_ready = ordy;
        pend  = bus.out_valid && !ordy;
        prow  = bus.out_row;
        pdata = bus.out_data;
        if (bus.out_valid && ordy) begin
          check("row_index", bus.out_row, nr);
          check($sformatf("row_data_%0d", nr), bus.out_data, exp_row(nr));
          nr++;
          last_hs = cyc;
        end
        vld = (beat < v.k) && (v.stall == 0 || (v.stall == 1 && cyc % 2 == 0) ||
              (v.stall == 2 && $urandom_range(0, 1) == 1));
        bus.in_valid = vld;
        for (int r = 0; r < N; r++) begin
          bus.a_col[r*DW +: DW] = vld ? ga[r][v.off+beat] : $urandom;
          bus.b_row[r*DW +: DW] = vld ? gb[v.off+beat][r] : $urandom;
        end
        if (vld && bus.in_ready) beat++;
        bus.start = v.noise; bus.acc_clear = 1'b1; bus.k_len = '0;
        @(posedge clock); #1;
      end
    end
    if (!fin) check("op_timeout", 0, 1);
    check("beats_taken", beat, v.k);
    check("ready_after_k", extra, 0);
    if (v.lat >= 0) check("first_valid_cycle", first_ov, v.lat);
    idle_inputs();
  endtask

  initial begin
    tbl[0] = '{1, 4,  0, GEN_IDENT, 0, 0, 0, 11};
    tbl[1] = '{1, 3,  0, GEN_RAND,  1, 0, 0, 12};
    tbl[2] = '{1, 2,  0, GEN_RAND,  0, 0, 0, 9};
    tbl[3] = '{0, 2,  2, GEN_KEEP,  0, 0, 0, 9};
    tbl[4] = '{1, 4,  0, GEN_KEEP,  0, 0, 0, 11};
    tbl[5] = '{1, 4,  0, GEN_RAND,  0, 1, 0, 11};
    tbl[6] = '{0, 0,  0, GEN_KEEP,  0, 0, 0, 0};
    tbl[7] = '{1, 0,  0, GEN_KEEP,  0, 0, 1, 0};
    tbl[8] = '{1, 13, 0, GEN_RAND,  2, 2, 1, -1};
    tbl[9] = '{1, 64, 0, GEN_RAND,  0, 0, 0, 71};

    idle_inputs();
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) cm[r][c] = 0;
    repeat (3) @(posedge clock);
    #1;
    check_zero_outputs("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) run_op(tbl[i]);

    gen_mats(GEN_RAND);
    bus.start = 1'b1; bus.acc_clear = 1'b1; bus.k_len = KW'(2);
    @(posedge clock); #1;
    bus.start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.in_valid = 1'b1;
      for (int r = 0; r < N; r++) begin
        bus.a_col[r*DW +: DW] = ga[r][b];
        bus.b_row[r*DW +: DW] = gb[b][r];
      end
      @(posedge clock); #1;
    end
    bus.in_valid = 1'b0;
    check("flush_no_ready", bus.in_ready, 0);
    repeat (2) @(posedge clock);
    #1;
    check("mid_flush_busy", bus.busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    @(posedge clock); #3;
    reset_n = 1'b1;
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) cm[r][c] = 0;
    run_op('{0, 1, 0, GEN_RAND, 0, 0, 0, 8});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
